mux_rr_nx1: RTL and testbench



---
 rtl/mux_rr_nx1.sv | 103 ++++++++++
 tb/tb_mux_rr_nx1.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-input valid/ready stream mux with a one-deep registered output stage.
// Round-robin arbitration by default; define MUX_RR_FIXED_PRIO_EN for lowest-index-wins priority.
module mux_rr_nx1 #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [WIDTH-1:0] words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign words[gi] = in[gi*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] out_reg, out_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             valid_reg, valid_next;
  logic             can_accept;
  logic             load;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] search_base;
  logic [SEL_W-1:0] idx;
  logic             found;

  // The output stage can take a word when it is empty or being drained this cycle.
  assign can_accept = ~valid_reg | out_ready;
  assign load       = can_accept & (|in_valid);
  assign in_ready   = grant & {N{can_accept & ~rst}};

`ifdef MUX_RR_FIXED_PRIO_EN
  // A constant base of N-1 makes the search start at channel 0: lowest index wins.
  assign search_base = SEL_W'(N - 1);
`else
  logic [SEL_W-1:0] last_reg;

  assign search_base = last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= SEL_W'(N - 1);
    end else if (load) begin
      last_reg <= grant_idx;
    end
  end
`endif

  // Search starts one past the base and wraps modulo N; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SEL_W'((int'(search_base) + k) % N);
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    out_next   = out_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    if (load) begin
      out_next   = words[grant_idx];
      sel_next   = grant_idx;
      valid_next = 1'b1;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= out_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
    end
  end

  assign out       = out_reg;
  assign out_sel   = sel_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1 (WIDTH=8, N=4): directed scenarios plus a randomized run
// against a behavioural model of the arbitration and output-stage rules.
module tb_mux_rr_nx1;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_sel;

  always #5 clk = ~clk;

  mux_rr_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [WIDTH-1:0] m_out   = '0;
  int               m_sel   = 0;
  logic             m_valid = 1'b0;
  int               m_last  = N - 1;
  logic [N-1:0]     m_ready = '0;

  // Winner = requester at the smallest circular distance after the last grant.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int c = 0; c < N; c++) begin
      if (v[c]) begin
`ifdef MUX_RR_FIXED_PRIO_EN
        d = c;
`else
        d = (c - last - 1 + 2 * N) % N;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N*WIDTH-1:0] pack(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                               input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic ordy);
    int g;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    g = pick(v, m_last);
    m_ready = (!r && (!m_valid || ordy) && g >= 0) ? (N'(1) << g) : '0;
    #1;
  endtask

  task automatic tick();
    int g;
    g = pick(in_valid, m_last);
    if (rst) begin
      m_out = '0; m_sel = 0; m_valid = 1'b0; m_last = N - 1;
    end else if ((!m_valid || out_ready) && g >= 0) begin
      m_out = in_data[g*WIDTH +: WIDTH]; m_sel = g; m_valid = 1'b1; m_last = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b1111, pack(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", out); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d want=0", out_sel); end
  endtask

  task automatic test_single();
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    drive(1'b0, 4'b0100, pack(8'h00, 8'h00, 8'hA5, 8'h00), 1'b1);
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_in_ready got=%b want=0100", in_ready); end
    tick();
    total++; if (out !== 8'hA5) begin bad++; $display("FAIL single_out got=%h want=a5", out); end
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL single_out_sel got=%0d want=2", out_sel); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
    $display("single: out=%h sel=%0d", out, out_sel);
  endtask

  task automatic test_rotation();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b1111, pack(8'h10, 8'h21, 8'h32, 8'h43), 1'b1);
      total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rot_in_ready[%0d] got=%b want=%b", i, in_ready, m_ready); end
      tick();
      total++; if (out_sel !== SEL_W'(exp_seq[i])) begin bad++; $display("FAIL rot_sel[%0d] got=%0d want=%0d", i, out_sel, exp_seq[i]); end
      total++; if (out !== m_out || out_valid !== 1'b1) begin bad++; $display("FAIL rot_out[%0d] got=%h/%b want=%h/1", i, out, out_valid, m_out); end
      $display("rotation %0d: sel=%0d out=%h", i, out_sel, out);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    drive(1'b0, 4'b0010, pack(8'h00, 8'h5A, 8'h00, 8'h00), 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1001, pack(8'hC0, 8'h00, 8'h00, 8'hC3), 1'b0);
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0000", i, in_ready); end
      tick();
      total++; if (out !== 8'h5A || out_sel !== 2'd1 || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h/%0d/%b want=5a/1/1", i, out, out_sel, out_valid);
      end
    end
    drive(1'b0, 4'b1001, pack(8'hC0, 8'h00, 8'h00, 8'hC3), 1'b1);
    total++; if (in_ready !== m_ready) begin bad++; $display("FAIL stall_release_ready got=%b want=%b", in_ready, m_ready); end
    tick();
    total++; if (out_sel !== SEL_W'(m_sel) || out !== m_out) begin bad++; $display("FAIL stall_release got=%0d/%h want=%0d/%h", out_sel, out, m_sel, m_out); end
`ifndef MUX_RR_FIXED_PRIO_EN
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL stall_release_ch3 got=%0d want=3", out_sel); end
`endif
    $display("stall release: sel=%0d out=%h", out_sel, out);
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] held;
    drive(1'b0, 4'b0001, pack(8'h7E, 8'h00, 8'h00, 8'h00), 1'b1); tick();
    held = out;
    total++; if (out_valid !== 1'b1 || out !== 8'h7E) begin bad++; $display("FAIL drain_load got=%h/%b want=7e/1", out, out_valid); end
    drive(1'b0, 4'b0000, pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    total++; if (out !== 8'h7E) begin bad++; $display("FAIL drain_out_kept got=%h want=7e", out); end
    $display("drain: out=%h valid=%b (was %h)", out, out_valid, held);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    drive(1'b0, 4'b0100, pack(8'h00, 8'h00, 8'h99, 8'h00), 1'b1); tick();
    drive(1'b0, 4'b1111, pack(8'h01, 8'h02, 8'h03, 8'h04), 1'b0); tick();
    drive(1'b1, 4'b1111, pack(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_in_ready got=%b want=0000", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out !== 8'h00) begin bad++; $display("FAIL rstmid_clear got=%h/%b want=00/0", out, out_valid); end
    drive(1'b0, 4'b1111, pack(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first_ready got=%b want=0001", in_ready); end
    tick();
    total++; if (out_sel !== 2'd0 || out !== 8'h01) begin bad++; $display("FAIL rstmid_first got=%0d/%h want=0/01", out_sel, out); end
    $display("reset mid-stall: first sel=%0d", out_sel);
  endtask

`ifdef MUX_RR_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1111, pack(8'h10, 8'h21, 8'h32, 8'h43), 1'b1);
      total++; if (in_ready[3:1] !== 3'b000) begin bad++; $display("FAIL fixed_ready[%0d] got=%b want=0001", i, in_ready); end
      tick();
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL fixed_sel[%0d] got=%0d want=0", i, out_sel); end
    end
  endtask
`endif

  task automatic test_random();
    logic r;
    logic o;
    drive(1'b1, 4'b0000, '0, 1'b1); tick();
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 49) == 0);
      o = ($urandom_range(0, 3) != 0);
      drive(r, N'($urandom), (N*WIDTH)'($urandom), o);
      total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", i, in_ready, m_ready); end
      tick();
      total++; if (out_valid !== m_valid || out !== m_out || out_sel !== SEL_W'(m_sel)) begin
        bad++; $display("FAIL rand_out[%0d] got=%b/%h/%0d want=%b/%h/%0d", i, out_valid, out, out_sel, m_valid, m_out, m_sel);
      end
    end
    $display("random: 300 cycles");
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
`ifdef MUX_RR_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_rotation();
`endif
    test_stall();
    test_drain();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
